// File: rtl/fpgnix_ddr_arb.sv
// fpgnix_ddr_arb: round-robin arbiter and sequencer that shares the SoC-DDR
// command/buffer interface between the GPP path (requester 0) and an
// accelerator (requester 1). Each granted transaction fills the 4-word
// buffer (store), issues the command, waits for status, drains the buffer
// (load), then pulses done back to the owner.
module fpgnix_ddr_arb #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter int          BUF_WORDS   = 4
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic [1:0]   req,
    input  logic [63:0]  req_cmd,
    input  logic [255:0] req_wdata,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [127:0] rsp_rdata,
    output logic [31:0]  rsp_status,
    output logic         rsp_err,
    output logic [31:0]  soc_ddr_cmd,
    output logic         soc_ddr_cmd_valid,
    input  logic [31:0]  soc_ddr_status,
    output logic [1:0]   soc_ddr_data_buf_idx,
    output logic         soc_ddr_buf_wr,
    output logic         soc_ddr_buf_rd,
    output logic [31:0]  soc_ddr_data_in,
    input  logic [31:0]  soc_ddr_data_out
);

    localparam logic [1:0] IDX_LAST = 2'(BUF_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUF_WR,
        S_CMD,
        S_GUARD,
        S_WAIT_STAT,
        S_BUF_RD,
        S_RD_LAST,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           last_q;
    logic [1:0]     gnt_q;
    logic [31:0]    cmd_q;
    logic [127:0]   wdata_q;
    logic [1:0]     idx_q;
    logic [15:0]    tmo_q;
    logic [127:0]   rsp_rdata_q;
    logic [31:0]    rsp_status_q;
    logic           rsp_err_q;

    logic           accept;
    logic           pick;
    logic [31:0]    cmd_sel;
    logic [127:0]   wdata_sel;
    logic           stat_rdy;
    logic           tmo_hit;
    logic [1:0]     idx_m1;

    // Round-robin winner selection and helper decodes
    always_comb begin
        accept    = |req;
        // With both requesting, the one that did not win last time goes next
        pick      = (req == 2'b11) ? ~last_q : req[1];
        cmd_sel   = pick ? req_cmd[63:32] : req_cmd[31:0];
        wdata_sel = pick ? req_wdata[255:128] : req_wdata[127:0];
        stat_rdy  = (soc_ddr_status != 32'd0);
        tmo_hit   = (tmo_q == TIMEOUT_CYC - 16'd1);
        // Read data lags buf_rd by one cycle, so capture goes to idx-1
        idx_m1    = idx_q - 2'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = cmd_sel[31] ? S_BUF_WR : S_CMD;
                end
            end
            S_BUF_WR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_CMD;
                end
            end
            S_CMD:   state_d = S_GUARD;
            // Status is stale here: the DDR block clears it in reaction to cmd_valid
            S_GUARD: state_d = S_WAIT_STAT;
            S_WAIT_STAT: begin
                if (stat_rdy) begin
                    state_d = cmd_q[31] ? S_DONE : S_BUF_RD;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_BUF_RD: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_RD_LAST;
                end
            end
            S_RD_LAST: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        gnt                  = gnt_q;
        done                 = (state_q == S_DONE) ? gnt_q : 2'b00;
        rsp_rdata            = rsp_rdata_q;
        rsp_status           = rsp_status_q;
        rsp_err              = rsp_err_q;
        soc_ddr_cmd          = cmd_q;
        soc_ddr_cmd_valid    = (state_q == S_CMD);
        soc_ddr_buf_wr       = (state_q == S_BUF_WR);
        soc_ddr_buf_rd       = (state_q == S_BUF_RD);
        soc_ddr_data_buf_idx = ((state_q == S_BUF_WR) || (state_q == S_BUF_RD)) ? idx_q : 2'b00;
        soc_ddr_data_in      = (state_q == S_BUF_WR) ? wdata_q[{idx_q, 5'd0} +: 32] : 32'd0;
    end

    // Grant, command latch, counters and response registers
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            last_q       <= 1'b1;
            gnt_q        <= 2'b00;
            cmd_q        <= 32'd0;
            idx_q        <= 2'd0;
            tmo_q        <= 16'd0;
            rsp_rdata_q  <= 128'd0;
            rsp_status_q <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        last_q <= pick;
                        gnt_q  <= pick ? 2'b10 : 2'b01;
                        cmd_q  <= cmd_sel;
                        idx_q  <= 2'd0;
                        tmo_q  <= 16'd0;
                    end
                end
                S_BUF_WR: begin
                    idx_q <= idx_q + 2'd1;
                end
                S_WAIT_STAT: begin
                    if (stat_rdy) begin
                        rsp_status_q <= soc_ddr_status;
                        rsp_err_q    <= 1'b0;
                        idx_q        <= 2'd0;
                    end else if (tmo_hit) begin
                        rsp_status_q <= 32'd0;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_BUF_RD: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q != 2'd0) begin
                        rsp_rdata_q[{idx_m1, 5'd0} +: 32] <= soc_ddr_data_out;
                    end
                end
                S_RD_LAST: begin
                    rsp_rdata_q[127:96] <= soc_ddr_data_out;
                end
                S_DONE: begin
                    gnt_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Store payload latch; only consumed in BUF_WR so it needs no reset
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && accept) begin
            wdata_q <= wdata_sel;
        end
    end

endmodule

// File: tb/tb_fpgnix_ddr_arb.sv
// Testbench for fpgnix_ddr_arb: directed and randomized transactions against
// a transaction-level reference model, with a simple DDR responder model.
module tb_fpgnix_ddr_arb;

    localparam int TO_CYC = 10;

    logic         clk;
    logic         sys_rst;
    logic [1:0]   req;
    logic [63:0]  req_cmd;
    logic [255:0] req_wdata;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [127:0] rsp_rdata;
    logic [31:0]  rsp_status;
    logic         rsp_err;
    logic [31:0]  soc_ddr_cmd;
    logic         soc_ddr_cmd_valid;
    logic [31:0]  soc_ddr_status;
    logic [1:0]   soc_ddr_data_buf_idx;
    logic         soc_ddr_buf_wr;
    logic         soc_ddr_buf_rd;
    logic [31:0]  soc_ddr_data_in;
    logic [31:0]  soc_ddr_data_out = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic         m_last;
    logic [127:0] m_rdata;
    int           g_rise;
    int           d_cyc;

    // DDR responder knobs
    int           st_delay;
    logic [31:0]  st_val;
    logic [31:0]  st_stale;
    bit           st_never;
    bit           stale_guard;
    logic [31:0]  rd_words [4];
    int           k = 0;

    fpgnix_ddr_arb #(
        .TIMEOUT_CYC (16'(TO_CYC)),
        .BUF_WORDS   (4)
    ) dut (
        .clk                  (clk),
        .sys_rst              (sys_rst),
        .req                  (req),
        .req_cmd              (req_cmd),
        .req_wdata            (req_wdata),
        .gnt                  (gnt),
        .done                 (done),
        .rsp_rdata            (rsp_rdata),
        .rsp_status           (rsp_status),
        .rsp_err              (rsp_err),
        .soc_ddr_cmd          (soc_ddr_cmd),
        .soc_ddr_cmd_valid    (soc_ddr_cmd_valid),
        .soc_ddr_status       (soc_ddr_status),
        .soc_ddr_data_buf_idx (soc_ddr_data_buf_idx),
        .soc_ddr_buf_wr       (soc_ddr_buf_wr),
        .soc_ddr_buf_rd       (soc_ddr_buf_rd),
        .soc_ddr_data_in      (soc_ddr_data_in),
        .soc_ddr_data_out     (soc_ddr_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DDR block model: k counts cycles since the command pulse (1 = GUARD cycle)
    always @(posedge clk) begin
        if (soc_ddr_cmd_valid) k <= 1;
        else if (k != 0)       k <= k + 1;
        if (soc_ddr_buf_rd) soc_ddr_data_out <= rd_words[soc_ddr_data_buf_idx];
    end

    // Status: optionally stale in the GUARD cycle, then zero for st_delay
    // WAIT_STAT cycles, then st_val (or zero forever when st_never)
    always_comb begin
        soc_ddr_status = 32'd0;
        if (k == 1) begin
            soc_ddr_status = stale_guard ? st_stale : 32'd0;
        end else if (k >= 2 && !st_never && (k - 2) >= st_delay) begin
            soc_ddr_status = st_val;
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, {gnt, done, rsp_err, soc_ddr_cmd_valid, soc_ddr_data_buf_idx,
                            soc_ddr_buf_wr, soc_ddr_buf_rd}, 128'd0);
        chk({tag, ".cmd"}, soc_ddr_cmd, 128'd0);
        chk({tag, ".din"}, soc_ddr_data_in, 128'd0);
        chk({tag, ".stat"}, rsp_status, 128'd0);
        chk({tag, ".rdata"}, rsp_rdata, 128'd0);
    endtask

    // One complete transaction, predicted from the request vector and the
    // responder knobs, then observed cycle by cycle on the falling edge.
    task automatic run_txn(input logic [1:0] rq, input string tag, input bit drop_mid, input bit hold_req);
        logic         own;
        logic [1:0]   gexp;
        logic [31:0]  c;
        logic [127:0] w;
        logic [127:0] exp_rdata;
        logic [31:0]  cv;
        bit           st;
        bit           to;
        int           waitc;
        int           lat_exp;
        int           n;
        int           bad;
        logic [1:0]   wr_idx [$];
        logic [31:0]  wr_dat [$];
        logic [1:0]   rd_idx [$];
        logic [31:0]  cmd_seen [$];

        own     = (rq == 2'b11) ? ~m_last : rq[1];
        m_last  = own;
        gexp    = own ? 2'b10 : 2'b01;
        c       = own ? req_cmd[63:32] : req_cmd[31:0];
        w       = own ? req_wdata[255:128] : req_wdata[127:0];
        st      = c[31];
        to      = st_never;
        waitc   = to ? TO_CYC : st_delay + 1;
        lat_exp = (st ? 4 : 0) + 2 + waitc + ((!st && !to) ? 5 : 0) + 1;
        exp_rdata = (!st && !to) ? {rd_words[3], rd_words[2], rd_words[1], rd_words[0]} : m_rdata;

        req = rq;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < 20);
        chk({tag, ".gnt"}, gnt, gexp);
        g_rise = cyc;
        if (drop_mid) req = 2'b00;

        bad = 0;
        for (int t = 0; t < 100; t++) begin
            if (gnt !== gexp) bad++;
            if (soc_ddr_buf_wr) begin
                wr_idx.push_back(soc_ddr_data_buf_idx);
                wr_dat.push_back(soc_ddr_data_in);
            end
            if (soc_ddr_cmd_valid) cmd_seen.push_back(soc_ddr_cmd);
            if (soc_ddr_buf_rd) rd_idx.push_back(soc_ddr_data_buf_idx);
            if (done !== 2'b00) break;
            tick();
        end
        d_cyc = cyc;

        chk({tag, ".done"}, done, gexp);
        chk({tag, ".gnt_hold"}, bad, 0);
        if (st || to) chk({tag, ".lat"}, d_cyc - g_rise + 1, lat_exp);
        chk({tag, ".n_wr"}, wr_idx.size(), st ? 4 : 0);
        for (int i = 0; i < wr_idx.size(); i++) begin
            chk($sformatf("%s.wr_idx%0d", tag, i), wr_idx[i], i);
            chk($sformatf("%s.wr_dat%0d", tag, i), wr_dat[i], w[32*i +: 32]);
        end
        chk({tag, ".n_cmd"}, cmd_seen.size(), 1);
        if (cmd_seen.size() != 0) cv = cmd_seen[0];
        else                      cv = 32'hxxxx_xxxx;
        chk({tag, ".cmd"}, cv, c);
        chk({tag, ".n_rd"}, rd_idx.size(), (!st && !to) ? 4 : 0);
        for (int i = 0; i < rd_idx.size(); i++) begin
            chk($sformatf("%s.rd_idx%0d", tag, i), rd_idx[i], i);
        end
        chk({tag, ".status"}, rsp_status, to ? 32'd0 : st_val);
        chk({tag, ".err"}, rsp_err, to);
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        m_rdata = exp_rdata;

        if (!hold_req) req = 2'b00;
        tick();
        chk({tag, ".idle_gnt"}, gnt, 2'b00);
        chk({tag, ".idle_done"}, done, 2'b00);
    endtask

    initial begin
        int dprev;
        logic [1:0] rq;

        sys_rst     = 1'b1;
        req         = 2'b00;
        req_cmd     = 64'd0;
        req_wdata   = 256'd0;
        st_delay    = 0;
        st_val      = 32'd1;
        st_stale    = 32'hDEAD_0001;
        st_never    = 1'b0;
        stale_guard = 1'b0;
        for (int i = 0; i < 4; i++) rd_words[i] = 32'd0;
        m_last      = 1'b1;
        m_rdata     = 128'd0;

        // Reset state
        repeat (3) tick();
        chk_zero("reset");
        sys_rst = 1'b0;
        tick();

        // Both requesters together: 0 first, then strict alternation
        req_cmd   = {32'h0000_0100, 32'h8000_0040};
        req_wdata = {128'h5555_0004_5555_0003_5555_0002_5555_0001,
                     32'h44, 32'h33, 32'h22, 32'h11};
        rd_words[0] = 32'hA0; rd_words[1] = 32'hA1; rd_words[2] = 32'hA2; rd_words[3] = 32'hA3;
        st_val = 32'd3; st_delay = 0;
        run_txn(2'b11, "rr0", 1'b0, 1'b1);
        dprev = d_cyc;
        run_txn(2'b11, "rr1", 1'b0, 1'b1);
        chk("rr.gap1", g_rise - dprev, 2);
        dprev = d_cyc;
        run_txn(2'b11, "rr2", 1'b0, 1'b1);
        chk("rr.gap2", g_rise - dprev, 2);
        dprev = d_cyc;
        run_txn(2'b11, "rr3", 1'b0, 1'b0);
        chk("rr.gap3", g_rise - dprev, 2);

        // Store by requester 0, status after two cycles past GUARD
        req_cmd[31:0]    = 32'h8000_0040;
        req_wdata[127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
        st_val = 32'd1; st_delay = 1;
        run_txn(2'b01, "store0", 1'b0, 1'b0);

        // Load by requester 1
        req_cmd[63:32] = 32'h0000_0100;
        st_val = 32'd5; st_delay = 0;
        run_txn(2'b10, "load1", 1'b0, 1'b0);

        // Timeout: status never arrives, nothing drained
        req_cmd[31:0] = 32'h0000_0300;
        st_never = 1'b1;
        run_txn(2'b01, "tmo", 1'b0, 1'b0);
        st_never = 1'b0;

        // Stale nonzero status during GUARD must be ignored
        req_cmd[63:32] = 32'h0000_0400;
        rd_words[0] = 32'hB0; rd_words[1] = 32'hB1; rd_words[2] = 32'hB2; rd_words[3] = 32'hB3;
        stale_guard = 1'b1; st_delay = 1; st_val = 32'd7;
        run_txn(2'b10, "stale", 1'b0, 1'b0);
        stale_guard = 1'b0;

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            rq = 2'($urandom_range(1, 3));
            req_cmd = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) req_wdata[32*i +: 32] = $urandom;
            for (int i = 0; i < 4; i++) rd_words[i] = $urandom;
            st_val      = $urandom | 32'd1;
            st_delay    = $urandom_range(0, 4);
            st_never    = ($urandom_range(0, 7) == 0);
            stale_guard = 1'($urandom_range(0, 1));
            run_txn(rq, $sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'b0);
        end
        st_never = 1'b0;
        stale_guard = 1'b0;
        st_delay = 0;

        // Reset in the middle of a load drain aborts silently
        req_cmd[31:0] = 32'h0000_0200;
        req = 2'b01;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (soc_ddr_buf_rd) break;
        end
        chk("rst.reach_rd", soc_ddr_buf_rd, 1'b1);
        sys_rst = 1'b1;
        req = 2'b00;
        tick();
        chk_zero("rst_mid");
        for (int t = 0; t < 3; t++) begin
            tick();
            chk($sformatf("rst.no_done%0d", t), {gnt, done}, 4'd0);
        end
        sys_rst = 1'b0;
        m_last  = 1'b1;
        m_rdata = 128'd0;
        tick();
        req_cmd[63:32] = 32'h0000_0500;
        rd_words[0] = 32'hC0; rd_words[1] = 32'hC1; rd_words[2] = 32'hC2; rd_words[3] = 32'hC3;
        st_val = 32'd9;
        run_txn(2'b10, "post_rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
